// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts by at most STEP bits per SHIFT cycle,
// with start/done handshake and a registered result held between operations.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic               zero,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MODE_SHL  = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHRA = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100
  } mode_e;

  // Step and width need one extra bit: STEP may equal WIDTH.
  localparam logic [SHAMT_W:0] STEP_L  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W+1)'(WIDTH);

  state_e             state, state_d;
  logic [WIDTH-1:0]   work, work_d;
  logic [2:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] rem, rem_d;
  logic [WIDTH-1:0]   result_d;
  logic               carry_d, zero_d, err_d;

  logic [SHAMT_W:0]   rem_ext, step_amt;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   shl_v, shr_v, sra_v, rol_v, ror_v, shifted;
  logic               step_bit;
  logic               start_illegal;

  // Per-step datapath: shift the working register by min(STEP, rem).
  always_comb begin
    rem_ext  = {1'b0, rem};
    step_amt = (rem_ext < STEP_L) ? rem_ext : STEP_L;
    rem_next = SHAMT_W'(rem_ext - step_amt);
    shl_v    = work << step_amt;
    shr_v    = work >> step_amt;
    sra_v    = $signed(work) >>> step_amt;
    rol_v    = (work << step_amt) | (work >> (WIDTH_L - step_amt));
    ror_v    = (work >> step_amt) | (work << (WIDTH_L - step_amt));
    // rol_v[0] is the last bit pushed out the top; ror_v[MSB] the last out the bottom.
    case (mode_q)
      MODE_SHL:  begin shifted = shl_v; step_bit = rol_v[0];       end
      MODE_SHR:  begin shifted = shr_v; step_bit = ror_v[WIDTH-1]; end
      MODE_SHRA: begin shifted = sra_v; step_bit = ror_v[WIDTH-1]; end
      MODE_ROL:  begin shifted = rol_v; step_bit = rol_v[0];       end
      MODE_ROR:  begin shifted = ror_v; step_bit = ror_v[WIDTH-1]; end
      default:   begin shifted = work;  step_bit = 1'b0;           end
    endcase
  end

  assign start_illegal = (mode > MODE_ROR);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d  = state;
    work_d   = work;
    mode_d   = mode_q;
    rem_d    = rem;
    result_d = result;
    carry_d  = carry_out;
    zero_d   = zero;
    err_d    = err;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d = operand;
          mode_d = mode;
          rem_d  = shamt;
          if (shamt == '0 || start_illegal) begin
            state_d  = ST_DONE;
            result_d = operand;
            carry_d  = 1'b0;
            zero_d   = (operand == '0);
            err_d    = start_illegal;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d  = ST_DONE;
          result_d = shifted;
          carry_d  = step_bit;
          zero_d   = (shifted == '0);
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      work      <= '0;
      mode_q    <= '0;
      rem       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      work      <= work_d;
      mode_q    <= mode_d;
      rem       <= rem_d;
      result    <= result_d;
      carry_out <= carry_d;
      zero      <= zero_d;
      err       <= err_d;
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=32, STEP=4): vector table plus
// hand-written handshake, mid-shift start and asynchronous-clear sequences.
module tb_seq_shift_unit;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;
  localparam int MAX_WAIT = 64;

  logic               clk;
  logic               clear;
  logic               start;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy, done, carry_out, zero, err;
  logic [WIDTH-1:0]   result;

  int n_pass  = 0;
  int n_total = 0;

  seq_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .Clock    (clk),
    .clear    (clear),
    .start    (start),
    .mode     (mode),
    .operand  (operand),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
    logic        exp_carry;
    logic        exp_zero;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Caller is at a negedge; drives start for exactly one rising edge.
  task automatic launch(input logic [2:0] m, input logic [31:0] op, input logic [4:0] sa);
    mode    = m;
    operand = op;
    shamt   = sa;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Counts busy cycles (sampled at negedge) until done is seen; bounded.
  task automatic wait_done(input string name, output int cycles);
    int i;
    cycles = 0;
    for (i = 0; i < MAX_WAIT; i++) begin
      if (done) break;
      if (busy) cycles++;
      @(negedge clk);
    end
    if (i == MAX_WAIT) begin
      n_total++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, MAX_WAIT);
    end
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{"shl_2",       3'b000, 32'h0000_0002, 5'd2,  32'h0000_0008, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{"shra_31",     3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8};
    vecs[2]  = '{"shr_31",      3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 8};
    vecs[3]  = '{"ror_1",       3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{"rol_4",       3'b011, 32'h8000_0000, 5'd4,  32'h0000_0008, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{"shl_31",      3'b000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 8};
    vecs[6]  = '{"shr_4_zero",  3'b001, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[7]  = '{"shamt0",      3'b000, 32'h1234_ABCD, 5'd0,  32'h1234_ABCD, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{"illegal_101", 3'b101, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 0};
    vecs[9]  = '{"rol_8",       3'b011, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{"ror_12",      3'b100, 32'h1234_5678, 5'd12, 32'h6781_2345, 1'b0, 1'b0, 1'b0, 3};
    vecs[11] = '{"shra_5_pos",  3'b010, 32'h7FFF_FFF0, 5'd5,  32'h03FF_FFFF, 1'b1, 1'b0, 1'b0, 2};
    vecs[12] = '{"shl_1_msb",   3'b000, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1'b0, 1'b0, 1};

    clear   = 1'b0;
    start   = 1'b0;
    mode    = '0;
    operand = '0;
    shamt   = '0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);

    check("reset_busy",   {31'b0, busy},      32'd0);
    check("reset_done",   {31'b0, done},      32'd0);
    check("reset_result", result,             32'd0);
    check("reset_carry",  {31'b0, carry_out}, 32'd0);
    check("reset_err",    {31'b0, err},       32'd0);

    for (int v = 0; v < NVEC; v++) begin
      launch(vecs[v].mode, vecs[v].operand, vecs[v].shamt);
      wait_done(vecs[v].name, cyc);
      check({vecs[v].name, "_busy_cycles"}, 32'(cyc), 32'(vecs[v].exp_busy));
      check({vecs[v].name, "_result"}, result, vecs[v].exp_result);
      check({vecs[v].name, "_carry"}, {31'b0, carry_out}, {31'b0, vecs[v].exp_carry});
      check({vecs[v].name, "_zero"},  {31'b0, zero},      {31'b0, vecs[v].exp_zero});
      check({vecs[v].name, "_err"},   {31'b0, err},       {31'b0, vecs[v].exp_err});
      @(negedge clk);
      check({vecs[v].name, "_done_pulse"}, {31'b0, done}, 32'd0);
      check({vecs[v].name, "_hold"}, result, vecs[v].exp_result);
    end

    // start pulsed with new data while busy must be ignored
    launch(3'b010, 32'h8000_0000, 5'd31);
    @(negedge clk);
    launch(3'b000, 32'h0000_0001, 5'd1);
    check("midshift_result_held", result, vecs[12].exp_result);
    wait_done("midshift", cyc);
    check("midshift_busy_left", 32'(cyc), 32'd6);
    check("midshift_result", result, 32'hFFFF_FFFF);
    @(negedge clk);

    // start held on the done cycle is accepted back-to-back
    launch(3'b000, 32'h0000_0002, 5'd2);
    wait_done("b2b_first", cyc);
    check("b2b_first_result", result, 32'h0000_0008);
    launch(3'b001, 32'h0000_0100, 5'd4);
    check("b2b_second_busy", {31'b0, busy}, 32'd1);
    wait_done("b2b_second", cyc);
    check("b2b_second_result", result, 32'h0000_0010);
    check("b2b_second_carry", {31'b0, carry_out}, 32'd0);
    @(negedge clk);

    // asynchronous clear for 3 ns between clock edges mid-SHIFT
    launch(3'b010, 32'h8000_0000, 5'd31);
    @(negedge clk);
    #1 clear = 1'b0;
    #1;
    check("clear_busy",   {31'b0, busy}, 32'd0);
    check("clear_done",   {31'b0, done}, 32'd0);
    check("clear_result", result,        32'd0);
    #2 clear = 1'b1;
    @(negedge clk);
    check("after_clear_idle", {31'b0, busy}, 32'd0);
    launch(3'b000, 32'h0000_0001, 5'd1);
    wait_done("after_clear", cyc);
    check("after_clear_busy_cycles", 32'(cyc), 32'd1);
    check("after_clear_result", result, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle shift/rotate unit for the datapath ALU. It generalises the single-operation shift-left path into a parametrised width and step size, with five modes and a start/done handshake. It sits beside the combinational ALU. The control sequencer starts it during the execute step and stalls until done before driving the Z register.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)
STEP, 4, maximum bit positions shifted per SHIFT cycle; power of 2, 1..WIDTH

Ports:
Clock  input  1  system clock, rising-edge
clear  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising edge when state is IDLE or DONE
mode  input  3  000 shl, 001 shr, 010 shra, 011 rol, 100 ror; 101-111 illegal
operand  input  WIDTH  value to shift; captured with start
shamt  input  SHAMT_W  shift amount 0..WIDTH-1; captured with start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result, carry_out, zero and err are valid
result  output  WIDTH  registered result; held until the next done
carry_out  output  1  last bit shifted out
zero  output  1  result == 0; registered with result
err  output  1  illegal mode on the last completed operation

Behaviour:
- Reset
  - clear low forces state to IDLE immediately, regardless of Clock.
  - Clears busy, done, result, carry_out, zero, err, the working register and the remaining counter.
  - Any in-flight operation is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE or DONE with start=1 at an edge:
  - Latches operand into the working register, and mode and shamt into internal registers.
  - rem is set to shamt.
  - If shamt=0 or the mode is illegal, the next state is DONE. Otherwise the next state is SHIFT.
- IDLE or DONE with start=0:
  - DONE goes to IDLE. IDLE stays in IDLE.
- SHIFT, each edge:
  - s = min(STEP, rem). The working register is shifted or rotated by s. rem = rem - s.
  - The bit-tracking register takes the last bit removed in this step.
  - When rem reaches 0, the next state is DONE.
- Entering DONE loads result, carry_out, zero and err from the working state.
- Outputs
  - busy = (state==SHIFT).
  - done = (state==DONE); it lasts exactly one cycle unless start is also asserted on that cycle.
- Latency: n = ceil(shamt/STEP). The start edge is E0, and done is high in the cycle after edge E0+n. For shamt=0, done is high in the cycle right after E0.
- start asserted while busy is ignored; the latched operands are unaffected.
- Modes
  - shl fills with 0 from the LSB. carry_out = original bit[WIDTH-shamt].
  - shr fills with 0 from the MSB. carry_out = original bit[shamt-1].
  - shra replicates the original MSB. carry_out = original bit[shamt-1].
  - rol: carry_out = result[0].
  - ror: carry_out = result[WIDTH-1].
- shamt=0 (legal mode): result = operand, carry_out=0, err=0.
- Illegal mode: result = operand, carry_out=0, err=1, done after one cycle.
- result is never updated during SHIFT; it only changes on entry to DONE or on reset.

Test Plan:
All scenarios use WIDTH=32, STEP=4.
1. shl, operand=0x00000002, shamt=2 -> result=0x00000008, carry_out=0, zero=0. One busy cycle; done in the cycle after E0+1.
2. shra, operand=0x80000000, shamt=31 -> 8 busy cycles, result=0xFFFFFFFF, carry_out=0. shr on the same operand and shamt -> result=0x00000001.
3. ror, operand=0x00000001, shamt=1 -> result=0x80000000, carry_out=1. rol, operand=0x80000000, shamt=4 -> result=0x00000008, carry_out=0.
4. shl, operand=0x00000003, shamt=31 -> result=0x80000000, carry_out=1. shr, operand=0x0000000F, shamt=4 -> result=0, zero=1, carry_out=1.
5. Boundary and handshake:
   - shamt=0, operand=0x1234ABCD -> done in the cycle after E0, result=0x1234ABCD.
   - mode=101 -> err=1, result=operand.
   - start pulsed with new data mid-SHIFT -> ignored; the original result is produced.
   - start held on the done cycle -> a back-to-back op is accepted.
6. clear driven low for 3 ns mid-SHIFT, between clock edges -> busy, done and result drop to 0 immediately. A following shl 0x1 by 1 completes normally with result 0x00000002.
